cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ctrl -- multi-cycle CPU control sequencer.
//
// Steps each instruction through FETCH -> DECODE -> EXECUTE -> (MEM) -> WB
// and produces the datapath strobes for each step. Illegal opcodes and
// memory wait timeouts send it to TRAP, where it stays until reset.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   halt_i          blocks the start of the next fetch
//   instruction_i   instruction word (stable once imem_ready_i has been seen)
//   imem_ready_i    instruction memory data valid
//   dmem_ready_i    data memory access complete
//   imem_req_o      instruction fetch request
//   ir_en_o         instruction register load strobe
//   dmem_req_o      data access request
//   dmem_we_o       data access write qualifier
//   rf_wr_en_o      register file write enable
//   pc_en_o         PC advance strobe
//   retire_o        one-cycle pulse per retired instruction
//   state_o         current state encoding
//   trap_cause_o    0 none, 1 illegal opcode, 2 timeout
//   retire_cnt_o    retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module cpu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt_i,
    input  logic [31:0] instruction_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    output logic        imem_req_o,
    output logic        ir_en_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        rf_wr_en_o,
    output logic        pc_en_o,
    output logic        retire_o,
    output logic [2:0]  state_o,
    output logic [1:0]  trap_cause_o,
    output logic [31:0] retire_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    // R-type and I-ALU share one path through the sequencer.
    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_t;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // The counter holds the number of ready-low cycles already seen, so the
    // trap fires in the cycle that would make it reach TIMEOUT_CYCLES.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    // Holds IDLE for one full cycle after reset release.
    logic        started_q, started_d;

    logic imem_req, ir_en, dmem_req, dmem_we, rf_wr_en, pc_en, retire;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction_i[31:12];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = wait_q;
        cause_d   = cause_q;
        started_d = 1'b1;
        imem_req  = 1'b0;
        ir_en     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_wr_en  = 1'b0;
        pc_en     = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!halt_i && started_q) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready_i) begin
                    ir_en   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_DECODE: begin
                case (instruction_i[6:0])
                    OPC_R, OPC_I_ALU: begin
                        op_d    = OP_ALU;
                        state_d = S_EXECUTE;
                    end
                    OPC_LOAD: begin
                        op_d    = OP_LOAD;
                        state_d = S_EXECUTE;
                    end
                    OPC_STORE: begin
                        op_d    = OP_STORE;
                        state_d = S_EXECUTE;
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_EXECUTE: begin
                if (op_q == OP_ALU) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
                if (dmem_ready_i) begin
                    if (op_q == OP_STORE) begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = halt_i ? S_IDLE : S_FETCH;
                        wait_d  = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_WB: begin
                rf_wr_en = (instruction_i[11:7] != 5'd0);
                pc_en    = 1'b1;
                retire   = 1'b1;
                state_d  = halt_i ? S_IDLE : S_FETCH;
                wait_d   = '0;
            end

            // TRAP and the unused code 7 both hold until reset.
            default: begin
                state_d = state_q;
            end
        endcase

        retire_cnt_d = retire_cnt_q + {31'd0, retire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= OP_ALU;
            wait_q       <= '0;
            cause_q      <= CAUSE_NONE;
            retire_cnt_q <= '0;
            started_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            wait_q       <= wait_d;
            cause_q      <= cause_d;
            retire_cnt_q <= retire_cnt_d;
            started_q    <= started_d;
        end
    end

    assign imem_req_o   = imem_req;
    assign ir_en_o      = ir_en;
    assign dmem_req_o   = dmem_req;
    assign dmem_we_o    = dmem_we;
    assign rf_wr_en_o   = rf_wr_en;
    assign pc_en_o      = pc_en;
    assign retire_o     = retire;
    assign state_o      = state_q;
    assign trap_cause_o = cause_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl -- directed self-checking bench for cpu_ctrl.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        halt_i;
    logic [31:0] instruction_i;
    logic        imem_ready_i;
    logic        dmem_ready_i;
    logic        imem_req_o;
    logic        ir_en_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        rf_wr_en_o;
    logic        pc_en_o;
    logic        retire_o;
    logic [2:0]  state_o;
    logic [1:0]  trap_cause_o;
    logic [31:0] retire_cnt_o;

    int tests;
    int fails;
    int dreq_cycles;

    cpu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt_i       (halt_i),
        .instruction_i(instruction_i),
        .imem_ready_i (imem_ready_i),
        .dmem_ready_i (dmem_ready_i),
        .imem_req_o   (imem_req_o),
        .ir_en_o      (ir_en_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .rf_wr_en_o   (rf_wr_en_o),
        .pc_en_o      (pc_en_o),
        .retire_o     (retire_o),
        .state_o      (state_o),
        .trap_cause_o (trap_cause_o),
        .retire_cnt_o (retire_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        halt_i = 1'b0;
        instruction_i = 32'h0;
        imem_ready_i = 1'b0;
        dmem_ready_i = 1'b0;
        #3;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_cnt", retire_cnt_o, 32'd0);
        chk("reset_cause", 32'(trap_cause_o), 32'd0);
        chk("reset_imem_req", 32'(imem_req_o), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_one_cycle", 32'(state_o), 32'd0);
        step();
        chk("first_fetch", 32'(state_o), 32'd1);
        chk("fetch_imem_req", 32'(imem_req_o), 32'd1);
        chk("fetch_no_dmem", 32'(dmem_req_o), 32'd0);

        // ADD x3, zero-wait fetch
        instruction_i = 32'h002081B3;
        imem_ready_i = 1'b1;
        #1;
        chk("add_ir_en", 32'(ir_en_o), 32'd1);
        step();
        imem_ready_i = 1'b0;
        chk("add_decode", 32'(state_o), 32'd2);
        chk("add_decode_no_req", 32'(imem_req_o), 32'd0);
        step();
        chk("add_execute", 32'(state_o), 32'd3);
        step();
        chk("add_wb", 32'(state_o), 32'd5);
        chk("add_rf_wr", 32'(rf_wr_en_o), 32'd1);
        chk("add_retire", 32'(retire_o), 32'd1);
        chk("add_pc_en", 32'(pc_en_o), 32'd1);
        step();
        chk("add_back_fetch", 32'(state_o), 32'd1);
        chk("add_cnt", retire_cnt_o, 32'd1);
        chk("add_retire_pulse", 32'(retire_o), 32'd0);

        // LOAD with dmem_ready delayed 3 cycles
        instruction_i = 32'h0000A183;
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        step();
        step();
        chk("load_mem", 32'(state_o), 32'd4);
        dreq_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready_i = 1'b1;
            #1;
            if (dmem_req_o) dreq_cycles++;
            chk("load_we_low", 32'(dmem_we_o), 32'd0);
            step();
        end
        dmem_ready_i = 1'b0;
        chk("load_dreq_cycles", 32'(dreq_cycles), 32'd4);
        chk("load_wb", 32'(state_o), 32'd5);
        chk("load_rf_wr", 32'(rf_wr_en_o), 32'd1);
        step();
        chk("load_cnt", retire_cnt_o, 32'd2);

        // STORE, zero-wait dmem
        instruction_i = 32'h0020A023;
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        step();
        step();
        chk("store_mem", 32'(state_o), 32'd4);
        chk("store_we", 32'(dmem_we_o), 32'd1);
        chk("store_no_rf_wr", 32'(rf_wr_en_o), 32'd0);
        chk("store_no_imem", 32'(imem_req_o), 32'd0);
        dmem_ready_i = 1'b1;
        #1;
        chk("store_retire", 32'(retire_o), 32'd1);
        chk("store_pc_en", 32'(pc_en_o), 32'd1);
        step();
        dmem_ready_i = 1'b0;
        chk("store_back_fetch", 32'(state_o), 32'd1);
        chk("store_cnt", retire_cnt_o, 32'd3);

        // ADDI x1 with halt asserted during WB
        instruction_i = 32'h00100093;
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        step();
        step();
        halt_i = 1'b1;
        #1;
        chk("addi_rf_wr", 32'(rf_wr_en_o), 32'd1);
        step();
        chk("halt_idle", 32'(state_o), 32'd0);
        chk("halt_no_imem", 32'(imem_req_o), 32'd0);
        chk("halt_cnt", retire_cnt_o, 32'd4);
        step();
        chk("halt_stay_idle", 32'(state_o), 32'd0);
        halt_i = 1'b0;
        step();
        chk("unhalt_fetch", 32'(state_o), 32'd1);

        // imem_ready arrives on the 16th waiting cycle: no trap
        repeat (15) step();
        chk("wait15_fetch", 32'(state_o), 32'd1);
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        chk("ready16_decode", 32'(state_o), 32'd2);
        step();
        step();
        step();
        chk("ready16_cnt", retire_cnt_o, 32'd5);
        chk("ready16_fetch", 32'(state_o), 32'd1);

        // imem_ready held low: timeout trap after 16 cycles
        repeat (15) step();
        chk("timeout_not_yet", 32'(state_o), 32'd1);
        step();
        chk("timeout_trap", 32'(state_o), 32'd6);
        chk("timeout_cause", 32'(trap_cause_o), 32'd2);
        chk("timeout_req_drop", 32'(imem_req_o), 32'd0);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state_o), 32'd0);
        chk("async_rst_cause", 32'(trap_cause_o), 32'd0);
        chk("async_rst_cnt", retire_cnt_o, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rst2_fetch", 32'(state_o), 32'd1);

        // Illegal opcode 0x7F
        instruction_i = 32'h0000007F;
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        step();
        chk("illegal_trap", 32'(state_o), 32'd6);
        chk("illegal_cause", 32'(trap_cause_o), 32'd1);
        halt_i = 1'b1;
        imem_ready_i = 1'b1;
        dmem_ready_i = 1'b1;
        step();
        halt_i = 1'b0;
        step();
        chk("trap_hold", 32'(state_o), 32'd6);
        chk("trap_cause_hold", 32'(trap_cause_o), 32'd1);
        chk("trap_no_imem", 32'(imem_req_o), 32'd0);
        chk("trap_no_ir_en", 32'(ir_en_o), 32'd0);
        chk("trap_no_dmem", 32'(dmem_req_o), 32'd0);
        chk("trap_no_retire", 32'(retire_o), 32'd0);
        chk("trap_no_pc_en", 32'(pc_en_o), 32'd0);
        imem_ready_i = 1'b0;
        dmem_ready_i = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("trap_rst_state", 32'(state_o), 32'd0);
        chk("trap_rst_cause", 32'(trap_cause_o), 32'd0);
        chk("trap_rst_cnt", retire_cnt_o, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rst3_fetch", 32'(state_o), 32'd1);

        // Retire counter wrap
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        #1;
        chk("wrap_preload", retire_cnt_o, 32'hFFFFFFFF);
        instruction_i = 32'h002081B3;
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        step();
        step();
        chk("wrap_retire", 32'(retire_o), 32'd1);
        step();
        chk("wrap_cnt", retire_cnt_o, 32'd0);
        chk("wrap_fetch", 32'(state_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
